// File: rtl/apu_reg_uart_tx.sv
// Encodes a 4-byte square-channel register set into eight nibble-addressed UART frames.
// Optional macro DELTA_ONLY_EN skips nibbles 0..6 that match the last completed transfer.
module apu_reg_uart_tx #(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BAUD      = 9_600,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] reg_data,
    input  logic        reg_valid,
    output logic        reg_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $fatal(1, "apu_reg_uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    idx;
    logic [2:0]    first_idx;
    logic [2:0]    next_idx;
    logic [31:0]   shadow;
    logic [7:0]    frame;
    logic          accept;
    logic          bit_end;
    logic          frame_end;
    logic          last_frame;
    logic          done_r;

    assign accept     = reg_valid && reg_ready;
    assign bit_end    = (state != IDLE) && (baud_cnt == BAUD_LAST);
    assign frame_end  = bit_end && (state == STOP) && (bit_cnt == STOP_LAST);
    assign last_frame = (idx == 3'd7);
    assign frame      = {1'b0, idx, shadow[{idx, 2'b00} +: 4]};
    assign done       = done_r;

`ifdef DELTA_ONLY_EN
    logic [31:0] last_sent;
    logic        last_valid;
    logic [7:0]  send_mask;
    logic [7:0]  accept_mask;

    function automatic logic [2:0] lowest_from(input logic [7:0] mask, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= lo)) r = 3'(i);
        end
        return r;
    endfunction

    // Nibble 7 always goes out: the receiver commits all four registers on it.
    always_comb begin
        accept_mask = 8'h80;
        for (int i = 0; i < 7; i++) begin
            accept_mask[i] = !last_valid || (reg_data[4*i +: 4] != last_sent[4*i +: 4]);
        end
    end

    assign first_idx = lowest_from(accept_mask, 3'd0);
    assign next_idx  = lowest_from(send_mask, idx + 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sent  <= 32'd0;
            last_valid <= 1'b0;
            send_mask  <= 8'd0;
        end else begin
            if (accept) send_mask <= accept_mask;
            if (frame_end && last_frame) begin
                last_sent  <= shadow;
                last_valid <= 1'b1;
            end
        end
    end
`else
    assign first_idx = 3'd0;
    assign next_idx  = idx + 3'd1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (frame_end) state_next = last_frame ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        reg_ready = (state == IDLE);
        busy      = (state != IDLE);
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = frame[bit_cnt];
            default: tx = 1'b1;
        endcase
    end

    // The baud counter is held at zero while idle so every frame starts phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            idx      <= 3'd0;
            shadow   <= 32'd0;
            done_r   <= 1'b0;
        end else begin
            done_r <= frame_end && last_frame;
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + 1'b1;
            if (bit_end) begin
                if ((state == DATA && bit_cnt != 3'd7) || (state == STOP && bit_cnt != STOP_LAST))
                    bit_cnt <= bit_cnt + 3'd1;
                else
                    bit_cnt <= 3'd0;
            end
            if (accept) begin
                shadow <= reg_data;
                idx    <= first_idx;
            end else if (frame_end && !last_frame) begin
                idx <= next_idx;
            end
        end
    end
endmodule

// File: tb/tb_apu_reg_uart_tx.sv
// Bench for apu_reg_uart_tx: random handshake traffic against a per-cycle bitstream
// model, plus directed transfers decoded from tx and pinned to literal frame bytes.
module tb_apu_reg_uart_tx;
    localparam int CLK_HZ    = 60;
    localparam int BAUD      = 12;
    localparam int STOP_BITS = 1;
    localparam int DIV       = CLK_HZ / BAUD;
    localparam int FL        = (9 + STOP_BITS) * DIV;
    localparam int XFER      = 8 * FL;
    localparam int MAXREC    = 2 * XFER + 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] reg_data = 32'd0;
    logic        reg_valid = 1'b0;
    logic        reg_ready;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    bit          exp_q[$];
    bit          exp_done = 1'b0;
    logic [31:0] last_sent = 32'd0;
    bit          last_valid = 1'b0;
    logic [31:0] cur_data = 32'd0;

    logic rec_tx    [0:MAXREC];
    logic rec_done  [0:MAXREC];
    logic rec_ready [0:MAXREC];

    apu_reg_uart_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reg_data(reg_data),
        .reg_valid(reg_valid),
        .reg_ready(reg_ready),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected line waveform of one transfer, one entry per clock.
    function automatic void buildStream(input logic [31:0] d);
        logic [7:0] byte_v;
        logic [3:0] nib;
        for (int i = 0; i < 8; i++) begin
            nib = d[4*i +: 4];
`ifdef DELTA_ONLY_EN
            if (i != 7 && last_valid && nib == last_sent[4*i +: 4]) continue;
`endif
            byte_v = {1'b0, 3'(i), nib};
            repeat (DIV) exp_q.push_back(1'b0);
            for (int j = 0; j < 8; j++) begin
                repeat (DIV) exp_q.push_back(byte_v[j]);
            end
            repeat (DIV * STOP_BITS) exp_q.push_back(1'b1);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done   = 1'b0;
            last_valid = 1'b0;
        end else begin
            checkOutput("tx", 32'(tx), 32'((exp_q.size() != 0) ? exp_q[0] : 1'b1));
            checkOutput("reg_ready", 32'(reg_ready), 32'(exp_q.size() == 0));
            checkOutput("busy", 32'(busy), 32'(exp_q.size() != 0));
            checkOutput("done", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    exp_done   = 1'b1;
                    last_sent  = cur_data;
                    last_valid = 1'b1;
                end
            end else if (reg_valid) begin
                cur_data = reg_data;
                buildStream(reg_data);
            end
        end
    end

    function automatic logic [7:0] decodeFrame(input int base);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = rec_tx[base + (j + 1) * DIV + DIV / 2];
        return b;
    endfunction

    task automatic resetDut();
        @(posedge clk); #1;
        rst = 1'b1;
        reg_valid = 1'b0;
        #1;
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_ready", 32'(reg_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (reg_ready !== 1'b1 && n < 3 * XFER) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle", 32'(reg_ready), 32'd1);
    endtask

    // Raises valid with data, drops it from cycle 'hold' on, and records ncycles after accept.
    task automatic applyStimulus(input logic [31:0] data, input int hold, input int ncycles);
        @(posedge clk); #1;
        reg_data  = data;
        reg_valid = 1'b1;
        for (int k = 1; k <= ncycles; k++) begin
            @(posedge clk); #1;
            if (k >= hold) begin
                reg_valid = 1'b0;
                reg_data  = $urandom;
            end
            @(negedge clk);
            rec_tx[k]    = tx;
            rec_done[k]  = done;
            rec_ready[k] = reg_ready;
        end
    endtask

    initial begin
        logic [7:0] exp_a [0:7];
        logic [7:0] exp_b [0:7];
        int w;
        int hold;
        int rst_at;
        exp_a = '{8'h02, 8'h18, 8'h27, 8'h3A, 8'h4C, 8'h57, 8'h69, 8'h70};
        exp_b = '{8'h0E, 8'h19, 8'h23, 8'h39, 8'h4A, 8'h53, 8'h6A, 8'h70};

        #1;
        checkOutput("init_tx", 32'(tx), 32'd1);
        checkOutput("init_ready", 32'(reg_ready), 32'd1);
        checkOutput("init_busy", 32'(busy), 32'd0);
        checkOutput("init_done", 32'(done), 32'd0);
        resetDut();

        // Single pulsed transfer with literal frame bytes and done latency.
        waitIdle();
        applyStimulus(32'h097CA782, 1, XFER + 5);
        checkOutput("latency_tx_low", 32'(rec_tx[1]), 32'd0);
        for (int f = 0; f < 8; f++) checkOutput("frame_a", 32'(decodeFrame(1 + f * FL)), 32'(exp_a[f]));
        checkOutput("done_not_early", 32'(rec_done[XFER]), 32'd0);
        checkOutput("done_at_end", 32'(rec_done[XFER + 1]), 32'd1);
        checkOutput("busy_until_end", 32'(rec_ready[XFER]), 32'd0);
        checkOutput("ready_after_end", 32'(rec_ready[XFER + 1]), 32'd1);

        // Valid held high: back-to-back transfers, next accept coincides with done.
        resetDut();
        waitIdle();
        applyStimulus(32'h0A3A939E, XFER + 2, 2 * XFER + 5);
        for (int f = 0; f < 8; f++) checkOutput("frame_b1", 32'(decodeFrame(1 + f * FL)), 32'(exp_b[f]));
        checkOutput("held_done", 32'(rec_done[XFER + 1]), 32'd1);
        checkOutput("held_ready", 32'(rec_ready[XFER + 1]), 32'd1);
        checkOutput("held_restart", 32'(rec_tx[XFER + 2]), 32'd0);
`ifdef DELTA_ONLY_EN
        checkOutput("frame_b2_delta", 32'(decodeFrame(XFER + 2)), 32'h70);
        checkOutput("held_done2", 32'(rec_done[XFER + 2 + FL]), 32'd1);
`else
        for (int f = 0; f < 8; f++) checkOutput("frame_b2", 32'(decodeFrame(XFER + 2 + f * FL)), 32'(exp_b[f]));
        checkOutput("held_done2", 32'(rec_done[2 * XFER + 2]), 32'd1);
`endif

        // Reset during the start bit of frame 3, then a clean resend.
        resetDut();
        waitIdle();
        @(posedge clk); #1;
        reg_data  = 32'h097CA782;
        reg_valid = 1'b1;
        @(posedge clk); #1;
        reg_valid = 1'b0;
        repeat (3 * FL + 1) @(posedge clk);
        #1;
        checkOutput("pre_rst_tx_low", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_tx", 32'(tx), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(reg_ready), 32'd1);
        applyStimulus(32'h097CA783, 1, XFER + 5);
        w = 0;
        while (w < 3 * DIV && rec_tx[1 + w] === 1'b0) w++;
        checkOutput("start_bit_width", 32'(w), 32'(DIV));
        checkOutput("resend_frame0", 32'(decodeFrame(1)), 32'h03);
        checkOutput("resend_frame7", 32'(decodeFrame(1 + 7 * FL)), 32'h70);
        checkOutput("resend_done", 32'(rec_done[XFER + 1]), 32'd1);

`ifdef DELTA_ONLY_EN
        resetDut();
        waitIdle();
        applyStimulus(32'h097CA782, 1, XFER + 5);
        waitIdle();
        applyStimulus(32'h097CA783, 1, 2 * FL + 5);
        checkOutput("delta_frame0", 32'(decodeFrame(1)), 32'h03);
        checkOutput("delta_frame1", 32'(decodeFrame(1 + FL)), 32'h70);
        checkOutput("delta_done", 32'(rec_done[2 * FL + 1]), 32'd1);
`endif

        // Random traffic: pulses, long holds, data churn while busy, one async reset.
        resetDut();
        hold   = 0;
        rst_at = 2000 + $urandom_range(0, 400);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            reg_data = $urandom;
            if (hold > 0) begin
                reg_valid = 1'b1;
                hold--;
            end else begin
                reg_valid = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 299) == 0) hold = $urandom_range(1, 2 * XFER);
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                checkOutput("rand_rst_tx", 32'(tx), 32'd1);
                @(posedge clk); #1;
                rst = 1'b0;
            end
        end
        reg_valid = 1'b0;
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
